// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press/release/long/repeat events.
// Optional double-click detection (GAP state, odouble) is enabled by defining BTN_DOUBLE_CLICK_EN.
module button_event_gen #(
    parameter int CLK_PER_TICK = 50000,
    parameter int LONG_TICKS   = 800,
    parameter int REP_TICKS    = 150,
    parameter int DBL_TICKS    = 300
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic iin,
    output logic opress,
    output logic orelease,
    output logic olong,
    output logic orep,
    output logic oheld,
    output logic odouble
);

    localparam int MAX_LR = (LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS;
    localparam int MAX_T  = (MAX_LR > DBL_TICKS) ? MAX_LR : DBL_TICKS;
    localparam int CW     = $clog2(MAX_T + 1);
    localparam int PW     = $clog2(CLK_PER_TICK);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
`ifdef BTN_DOUBLE_CLICK_EN
        , GAP
`endif
    } state_t;

    state_t          state;
    logic            prev;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   tick_cnt;
    logic            press_e;
    logic            release_e;
    logic            tick;
    logic [CW-1:0]   cnt_nxt;

    assign press_e   = iin & ~prev;
    assign release_e = ~iin & prev;
    assign tick      = (presc == PW'(CLK_PER_TICK - 1));
    assign cnt_nxt   = tick_cnt + 1'b1;

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state    <= IDLE;
            prev     <= 1'b1;
            presc    <= '0;
            tick_cnt <= '0;
            opress   <= 1'b0;
            orelease <= 1'b0;
            olong    <= 1'b0;
            orep     <= 1'b0;
            oheld    <= 1'b0;
            odouble  <= 1'b0;
        end else begin
            prev     <= iin;
            opress   <= 1'b0;
            orelease <= 1'b0;
            olong    <= 1'b0;
            orep     <= 1'b0;
            odouble  <= 1'b0;
            case (state)
                IDLE: begin
                    presc    <= '0;
                    tick_cnt <= '0;
                    if (press_e) begin
                        opress <= 1'b1;
                        oheld  <= 1'b1;
                        state  <= HELD;
                    end
                end
                HELD: begin
                    // Release is tested first so it overrides a coincident threshold tick.
                    if (release_e) begin
                        orelease <= 1'b1;
                        oheld    <= 1'b0;
                        presc    <= '0;
                        tick_cnt <= '0;
`ifdef BTN_DOUBLE_CLICK_EN
                        state    <= GAP;
`else
                        state    <= IDLE;
`endif
                    end else if (tick) begin
                        presc <= '0;
                        if (cnt_nxt == CW'(LONG_TICKS)) begin
                            olong    <= 1'b1;
                            tick_cnt <= '0;
                            state    <= REPEAT;
                        end else begin
                            tick_cnt <= cnt_nxt;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                REPEAT: begin
                    if (release_e) begin
                        orelease <= 1'b1;
                        oheld    <= 1'b0;
                        presc    <= '0;
                        tick_cnt <= '0;
                        state    <= IDLE;
                    end else if (tick) begin
                        presc <= '0;
                        if (cnt_nxt == CW'(REP_TICKS)) begin
                            orep     <= 1'b1;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= cnt_nxt;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
`ifdef BTN_DOUBLE_CLICK_EN
                GAP: begin
                    if (press_e) begin
                        opress   <= 1'b1;
                        odouble  <= 1'b1;
                        oheld    <= 1'b1;
                        presc    <= '0;
                        tick_cnt <= '0;
                        state    <= HELD;
                    end else if (tick) begin
                        presc <= '0;
                        if (cnt_nxt == CW'(DBL_TICKS)) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= cnt_nxt;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    oheld    <= 1'b0;
                    presc    <= '0;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with small timing parameters (4/5/2/3).
// Output vectors are packed {press, release, long, rep, held, double}.
module tb_button_event_gen;

    logic iclk = 1'b0;
    logic irst_n = 1'b0;
    logic iin = 1'b0;
    logic opress, orelease, olong, orep, oheld, odouble;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 iclk = ~iclk;

    button_event_gen #(
        .CLK_PER_TICK(4),
        .LONG_TICKS  (5),
        .REP_TICKS   (2),
        .DBL_TICKS   (3)
    ) dut (
        .iclk    (iclk),
        .irst_n  (irst_n),
        .iin     (iin),
        .opress  (opress),
        .orelease(orelease),
        .olong   (olong),
        .orep    (orep),
        .oheld   (oheld),
        .odouble (odouble)
    );

    typedef struct {
        logic       rst_n;
        logic       in;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

`ifdef BTN_DOUBLE_CLICK_EN
    localparam logic DBL_ON = 1'b1;
`else
    localparam logic DBL_ON = 1'b0;
`endif

    task automatic step(input logic r, input logic i);
        @(negedge iclk);
        irst_n = r;
        iin    = i;
        @(posedge iclk);
        #1;
    endtask

    task automatic check(input string name, input int unsigned idx, input logic [5:0] exp);
        logic [5:0] act;
        act = {opress, orelease, olong, orep, oheld, odouble};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got p/r/l/rp/h/d=%b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic idle(input string name, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            step(1'b1, 1'b0);
            check(name, k, 6'b000000);
        end
    endtask

    function automatic logic [5:0] ev(input logic p, input logic r, input logic l,
                                      input logic rp, input logic h, input logic d);
        return {p, r, l, rp, h, d};
    endfunction

    initial begin
        // Reset state and test 1: 10-cycle short press.
        vecs.push_back('{1'b0, 1'b0, 6'b000000});
        vecs.push_back('{1'b0, 1'b1, 6'b000000});
        vecs.push_back('{1'b1, 1'b0, 6'b000000});
        vecs.push_back('{1'b1, 1'b0, 6'b000000});
        vecs.push_back('{1'b1, 1'b1, 6'b100010});
        for (int k = 0; k < 9; k++) vecs.push_back('{1'b1, 1'b1, 6'b000010});
        vecs.push_back('{1'b1, 1'b0, 6'b010000});
        vecs.push_back('{1'b1, 1'b0, 6'b000000});

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].rst_n, vecs[k].in);
            check("short_press", k, vecs[k].exp);
        end
        idle("idle1", 15);

        // Test 2: long hold, olong at +20, orep every 8 cycles after it.
        for (int c = 0; c <= 60; c++) begin
            step(1'b1, 1'b1);
            check("long_hold", c, ev(c == 0, 1'b0, c == 20,
                                     (c >= 28) && ((c - 20) % 8 == 0), 1'b1, 1'b0));
        end
        step(1'b1, 1'b0);
        check("long_release", 0, 6'b010000);
        idle("idle2", 4);

        // Test 3: release on the edge of the 5th tick wins over olong.
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b1);
            check("race_hold", c, ev(c == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        step(1'b1, 1'b0);
        check("race_release", 0, 6'b010000);
        idle("idle3", 15);

        // Test 4: reset mid-hold, button still held after reset.
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1);
            check("pre_reset_hold", c, ev(c == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1);
            check("in_reset", c, 6'b000000);
        end
        for (int c = 0; c < 30; c++) begin
            step(1'b1, 1'b1);
            check("held_after_reset", c, 6'b000000);
        end
        idle("no_release_after_reset", 4);

        // Tests 5/6: re-press 8 cycles after a release, then 13 cycles after.
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1);
            check("click1", c, ev(c == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        step(1'b1, 1'b0);
        check("click1_release", 0, 6'b010000);
        idle("gap_short", 7);
        step(1'b1, 1'b1);
        check("second_press_8", 0, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DBL_ON));
        step(1'b1, 1'b1);
        check("second_press_8_hold", 0, 6'b000010);
        step(1'b1, 1'b0);
        check("click2_release", 0, 6'b010000);
        idle("gap_long", 12);
        step(1'b1, 1'b1);
        check("second_press_13", 0, 6'b100010);
        step(1'b1, 1'b1);
        check("second_press_13_hold", 0, 6'b000010);
        step(1'b1, 1'b0);
        check("click3_release", 0, 6'b010000);
        idle("idle_end", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
